uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one uart_tx between NUM_REQ byte requesters.

---
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx between NUM_REQ
// byte requesters, with per-requester ack/done pulses and a tx_busy timeout.
module uart_tx_sched #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         done,
   output logic                       tx_start,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_busy,
   output logic                       active,
   output logic [$clog2(NUM_REQ)-1:0] cur_id,
   output logic                       timeout_err
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CTR_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ID_W-1:0]     last_grant_r;
   logic [ID_W-1:0]     last_grant_nxt_s;
   logic [CTR_W-1:0]    ctr_r;
   logic [CTR_W-1:0]    ctr_nxt_s;
   logic [CTR_W-1:0]    ctr_inc_s;
   logic [ID_W-1:0]     winner_s;
   logic                grant_s;
   logic                timeout_hit_s;
   logic                frame_end_s;
   logic [NUM_REQ-1:0]  ack_nxt_s;
   logic [NUM_REQ-1:0]  done_nxt_s;
   logic                tx_start_nxt_s;
   logic [DATA_W-1:0]   tx_data_nxt_s;
   logic                active_nxt_s;
   logic [ID_W-1:0]     cur_id_nxt_s;
   logic                timeout_nxt_s;

   // First set request after the last served requester, wrapping around.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    last);
      logic [ID_W-1:0] pick;
      int              idx;
      pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx  = (int'(last) + k) % NUM_REQ;
         pick = r[idx] ? ID_W'(idx) : pick;
      end
      return pick;
   endfunction

   // Arbitration and frame-event decode shared by the FSM processes.
   always_comb begin
      winner_s      = rr_pick(req, last_grant_r);
      grant_s       = (state_r == S_IDLE) && (|req) && !tx_busy;
      ctr_inc_s     = ctr_r + CTR_W'(1);
      timeout_hit_s = (state_r == S_WAIT_BUSY) && !tx_busy &&
                      (ctr_inc_s == CTR_W'(BUSY_TIMEOUT - 1));
      frame_end_s   = (state_r == S_WAIT_DONE) && !tx_busy;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (grant_s) state_nxt_s = S_LAUNCH;
            else         state_nxt_s = S_IDLE;
         end
         S_LAUNCH: state_nxt_s = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (tx_busy)            state_nxt_s = S_WAIT_DONE;
            else if (timeout_hit_s) state_nxt_s = S_IDLE;
            else                    state_nxt_s = S_WAIT_BUSY;
         end
         S_WAIT_DONE: begin
            if (frame_end_s) state_nxt_s = S_IDLE;
            else             state_nxt_s = S_WAIT_DONE;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered outputs and datapath.
   always_comb begin
      ack_nxt_s        = '0;
      done_nxt_s       = '0;
      tx_start_nxt_s   = 1'b0;
      timeout_nxt_s    = 1'b0;
      tx_data_nxt_s    = tx_data;
      cur_id_nxt_s     = cur_id;
      last_grant_nxt_s = last_grant_r;
      ctr_nxt_s        = ctr_r;
      case (state_r)
         S_IDLE: begin
            if (grant_s) begin
               tx_data_nxt_s  = req_data[int'(winner_s)*DATA_W +: DATA_W];
               cur_id_nxt_s   = winner_s;
               ack_nxt_s      = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
               tx_start_nxt_s = 1'b1;
            end else begin
               tx_start_nxt_s = 1'b0;
            end
         end
         S_LAUNCH: ctr_nxt_s = '0;
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               ctr_nxt_s = ctr_r;
            end else if (timeout_hit_s) begin
               timeout_nxt_s    = 1'b1;
               last_grant_nxt_s = cur_id;
               ctr_nxt_s        = ctr_inc_s;
            end else begin
               ctr_nxt_s = ctr_inc_s;
            end
         end
         S_WAIT_DONE: begin
            if (frame_end_s) begin
               done_nxt_s       = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_id;
               last_grant_nxt_s = cur_id;
            end else begin
               done_nxt_s = '0;
            end
         end
         default: ctr_nxt_s = '0;
      endcase
      active_nxt_s = (state_nxt_s != S_IDLE);
   end

   // Output and datapath registers; a reset makes requester 0 win first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack          <= '0;
         done         <= '0;
         tx_start     <= 1'b0;
         tx_data      <= '0;
         active       <= 1'b0;
         cur_id       <= '0;
         timeout_err  <= 1'b0;
         last_grant_r <= ID_W'(NUM_REQ - 1);
         ctr_r        <= '0;
      end else begin
         ack          <= ack_nxt_s;
         done         <= done_nxt_s;
         tx_start     <= tx_start_nxt_s;
         tx_data      <= tx_data_nxt_s;
         active       <= active_nxt_s;
         cur_id       <= cur_id_nxt_s;
         timeout_err  <= timeout_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         ctr_r        <= ctr_nxt_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a behavioural uart_tx busy model, a launch/done
// scoreboard, a table of arbitration bursts and hand-written corner cases.
module tb_uart_tx_sched;

   localparam int NUM_REQ      = 4;
   localparam int DATA_W       = 8;
   localparam int BUSY_TIMEOUT = 16;
   localparam int FRAME        = 20;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*DATA_W-1:0]    req_data;
   logic [NUM_REQ-1:0]           ack;
   logic [NUM_REQ-1:0]           done;
   logic                         tx_start;
   logic [DATA_W-1:0]            tx_data;
   logic                         tx_busy;
   logic                         active;
   logic [$clog2(NUM_REQ)-1:0]   cur_id;
   logic                         timeout_err;

   uart_tx_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .active(active),
      .cur_id(cur_id), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       exp_done;
   } sb_t;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      int          n;
      logic [7:0]  ord;
   } vec_t;

   sb_t        lq[$];
   sb_t        dq[$];
   vec_t       tbl[6];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         last_start = 0;
   int         cnt = 0;
   int         busy_mode = 0;   // 0 = uart model, 1 = stub never busy, 2 = forced busy
   bit         have_prev = 1'b0;
   bit         to_pend = 1'b0;
   logic [3:0] hold = 4'b0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   // One clock: monitor outputs, let requesters drop after ack, advance uart model.
   task automatic step();
      sb_t e;
      @(negedge clk);
      cyc++;
      if (tx_start) begin
         if (lq.size() == 0) begin
            flag("unexpected_start");
         end else begin
            e = lq.pop_front();
            check("launch_id", 32'(cur_id), 32'(e.id));
            check("launch_data", 32'(tx_data), 32'(e.data));
            check("launch_ack", 32'(ack), 32'(1) << e.id);
            check("launch_active", 32'(active), 32'd1);
            if (have_prev) check("start_gap", cyc - last_start, FRAME + 3);
            have_prev  = 1'b1;
            last_start = cyc;
            if (e.exp_done) dq.push_back(e);
            else            to_pend = 1'b1;
         end
      end else if (ack != 4'b0000) begin
         flag("ack_without_start");
      end
      if (done != 4'b0000) begin
         if (dq.size() == 0) begin
            flag("unexpected_done");
         end else begin
            e = dq.pop_front();
            check("done_onehot", 32'(done), 32'(1) << e.id);
            check("done_data_stable", 32'(tx_data), 32'(e.data));
            check("done_active", 32'(active), 32'd0);
         end
      end
      if (timeout_err) begin
         if (!to_pend) begin
            flag("unexpected_timeout");
         end else begin
            check("timeout_delay", cyc - last_start, BUSY_TIMEOUT);
            check("timeout_active", 32'(active), 32'd0);
            to_pend = 1'b0;
         end
      end
      req = req & ~(ack & ~hold);
      if (rst) begin
         cnt = 0;
         tx_busy = (busy_mode == 2);
      end else if (busy_mode == 2) begin
         tx_busy = 1'b1;
      end else if (busy_mode == 1) begin
         cnt = 0;
         tx_busy = 1'b0;
      end else begin
         if (cnt > 0) begin
            cnt--;
            tx_busy = (cnt != 0);
         end else begin
            tx_busy = 1'b0;
         end
         if (tx_start) cnt = FRAME + 1;
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((lq.size() != 0 || dq.size() != 0 || to_pend) && n < budget) begin
         step();
         n++;
      end
      check("drained_in_budget", 32'(lq.size() == 0 && dq.size() == 0 && !to_pend), 32'd1);
      step();
      step();
   endtask

   task automatic push(input int id, input logic [7:0] data, input logic exp_done);
      sb_t e;
      e.id = 2'(id);
      e.data = data;
      e.exp_done = exp_done;
      lq.push_back(e);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0] id;
      logic [3:0] ack_seen;
      int         n;

      tbl[0] = '{req: 4'b1111, data: 32'h44332211, n: 4, ord: 8'b11_10_01_00};
      tbl[1] = '{req: 4'b0001, data: 32'h000000A5, n: 1, ord: 8'b00_00_00_00};
      tbl[2] = '{req: 4'b1010, data: 32'h5A00C300, n: 2, ord: 8'b00_00_11_01};
      tbl[3] = '{req: 4'b0100, data: 32'h00FF0000, n: 1, ord: 8'b00_00_00_10};
      tbl[4] = '{req: 4'b1001, data: 32'h80000001, n: 2, ord: 8'b00_00_00_11};
      tbl[5] = '{req: 4'b0110, data: 32'h007EE700, n: 2, ord: 8'b00_00_10_01};

      rst = 1'b1;
      req = 4'b0000;
      req_data = '0;
      tx_busy = 1'b0;
      repeat (3) step();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_txstart_to_active", 32'({tx_start, timeout_err, active}), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_cur_id", 32'(cur_id), 32'd0);
      rst = 1'b0;
      step();

      // table-driven arbitration bursts
      for (int t = 0; t < 6; t++) begin
         have_prev = 1'b0;
         for (int k = 0; k < tbl[t].n; k++) begin
            id = tbl[t].ord[2*k +: 2];
            push(int'(id), tbl[t].data[int'(id)*8 +: 8], 1'b1);
         end
         id = tbl[t].ord[1:0];
         req_data = tbl[t].data;
         req = tbl[t].req;
         step();
         check("first_ack_latency", 32'(ack), 32'(1) << id);
         run_until_idle(400);
      end

      // requesters 0 and 2 held continuously: strict alternation
      have_prev = 1'b0;
      hold = 4'b0101;
      req_data = 32'h00C4003B;
      push(0, 8'h3B, 1'b1);
      push(2, 8'hC4, 1'b1);
      push(0, 8'h3B, 1'b1);
      push(2, 8'hC4, 1'b1);
      req = 4'b0101;
      n = 0;
      while (lq.size() != 0 && n < 400) begin
         step();
         n++;
      end
      req = 4'b0000;
      hold = 4'b0000;
      run_until_idle(400);

      // tx_busy never rises: timeout, then normal service resumes
      have_prev = 1'b0;
      busy_mode = 1;
      req_data = 32'h00001277;
      push(0, 8'h77, 1'b0);
      req = 4'b0001;
      run_until_idle(200);
      busy_mode = 0;
      have_prev = 1'b0;
      push(1, 8'h12, 1'b1);
      req = 4'b0010;
      run_until_idle(200);

      // reset while in WAIT_DONE aborts the frame
      have_prev = 1'b0;
      req_data = 32'h0062615E;
      push(0, 8'h5E, 1'b1);
      req = 4'b0001;
      n = 0;
      while (lq.size() != 0 && n < 50) begin
         step();
         n++;
      end
      repeat (5) step();
      check("pre_rst_busy", 32'(tx_busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ack_done", 32'({ack, done}), 32'd0);
      check("midrst_flags", 32'({tx_start, timeout_err, active}), 32'd0);
      check("midrst_tx_data", 32'(tx_data), 32'd0);
      check("midrst_cur_id", 32'(cur_id), 32'd0);
      dq.delete();
      step();
      step();
      req = 4'b0110;
      push(1, 8'h61, 1'b1);
      push(2, 8'h62, 1'b1);
      have_prev = 1'b0;
      rst = 1'b0;
      run_until_idle(400);

      // tx_busy held high in IDLE blocks the grant
      have_prev = 1'b0;
      busy_mode = 2;
      tx_busy = 1'b1;
      req_data = 32'hD3000000;
      req = 4'b1000;
      ack_seen = 4'b0000;
      repeat (10) begin
         step();
         ack_seen = ack_seen | ack;
      end
      check("busy_blocks_ack", 32'(ack_seen), 32'd0);
      check("busy_blocks_active", 32'(active), 32'd0);
      busy_mode = 0;
      tx_busy = 1'b0;
      push(3, 8'hD3, 1'b1);
      step();
      check("ack3_after_busy", 32'(ack), 32'h8);
      run_until_idle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
